// File: rtl/red_pitaya_rst_seq.sv
// red_pitaya_rst_seq: startup sequencer for GSR/PRLD, GTS and staggered per-domain resets
module red_pitaya_rst_seq #(
   parameter int ROC_CYCLES = 16,
   parameter int TOC_CYCLES = 4,
   parameter int LOCK_FILT  = 8,
   parameter int NUM_DOM    = 3,
   parameter int STAGGER    = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pll_locked_i,
   input  logic               sw_rst_i,
   output logic               gsr_o,
   output logic               prld_o,
   output logic               gts_o,
   output logic [NUM_DOM-1:0] dom_rstn_o,
   output logic               ready_o,
   output logic [2:0]         state_o,
   output logic [7:0]         restart_cnt_o
);
   typedef enum logic [2:0] {
      ST_RST       = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_HOLD_GSR  = 3'd2,
      ST_HOLD_GTS  = 3'd3,
      ST_RELEASE   = 3'd4,
      ST_RUN       = 3'd5
   } state_t;
   localparam int REL_LAST = (NUM_DOM - 1) * STAGGER;
   localparam int M1       = ROC_CYCLES > LOCK_FILT ? ROC_CYCLES : LOCK_FILT;
   localparam int M2       = TOC_CYCLES > REL_LAST ? TOC_CYCLES : REL_LAST;
   localparam int MAXC     = M1 > M2 ? M1 : M2;
   localparam int CW       = $clog2(MAXC + 1);
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [7:0]         rcnt_q, rcnt_d;
   logic               sync1_q, lock_s_q;
   logic               gsr_q, gsr_d, gts_q, gts_d, ready_q, ready_d;
   logic [NUM_DOM-1:0] dom_q, dom_d;
   logic               restart;
   // next state; one counter serves as lock filter in WAIT_LOCK and as hold/stagger timer elsewhere
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      restart = !lock_s_q || sw_rst_i;
      case (state_q)
         ST_RST: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end
         ST_WAIT_LOCK: begin
            if (restart) cnt_d = '0;
            else if (cnt_q == CW'(LOCK_FILT)) begin
               state_d = ST_HOLD_GSR;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         ST_HOLD_GSR: begin
            if (cnt_q == CW'(ROC_CYCLES - 1)) begin
               state_d = TOC_CYCLES == 0 ? ST_RELEASE : ST_HOLD_GTS;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         ST_HOLD_GTS: begin
            if (cnt_q == CW'(TOC_CYCLES - 1)) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         ST_RELEASE: begin
            if (cnt_q == CW'(REL_LAST)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         ST_RUN: state_d = ST_RUN;
         default: state_d = ST_RST;
      endcase
      if (restart && (state_q inside {ST_HOLD_GSR, ST_HOLD_GTS, ST_RELEASE, ST_RUN})) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = '0;
         rcnt_d  = rcnt_q + {7'd0, rcnt_q != 8'hFF};
      end
   end
   // outputs decoded from the next state so they change together with the state register
   always_comb begin
      gsr_d   = state_d inside {ST_RST, ST_WAIT_LOCK, ST_HOLD_GSR};
      gts_d   = gsr_d || state_d == ST_HOLD_GTS;
      ready_d = state_d == ST_RUN;
      for (int i = 0; i < NUM_DOM; i++)
         dom_d[i] = state_d == ST_RUN || (state_d == ST_RELEASE && int'(cnt_d) >= i * STAGGER);
   end
   // state, counters, lock synchroniser and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_RST;
         cnt_q    <= '0;
         rcnt_q   <= '0;
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
         gsr_q    <= 1'b1;
         gts_q    <= 1'b1;
         ready_q  <= 1'b0;
         dom_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rcnt_q   <= rcnt_d;
         sync1_q  <= pll_locked_i;
         lock_s_q <= sync1_q;
         gsr_q    <= gsr_d;
         gts_q    <= gts_d;
         ready_q  <= ready_d;
         dom_q    <= dom_d;
      end
   end
   assign gsr_o         = gsr_q;
   assign prld_o        = gsr_q;
   assign gts_o         = gts_q;
   assign dom_rstn_o    = dom_q;
   assign ready_o       = ready_q;
   assign state_o       = state_q;
   assign restart_cnt_o = rcnt_q;
endmodule

// File: tb/tb_red_pitaya_rst_seq.sv
// tb_red_pitaya_rst_seq: directed vector table plus corner sequences for the reset sequencer
module tb_red_pitaya_rst_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll = 1'b1;
   logic       sw  = 1'b0;
   logic       gsr, prld, gts, rdy;
   logic [2:0] dom, st;
   logic [7:0] rc;
   logic       z_gsr, z_prld, z_gts, z_rdy;
   logic [2:0] z_dom, z_st;
   logic [7:0] z_rc;
   int         tests = 0;
   int         fails = 0;

   typedef struct {
      int         n;
      logic       pll;
      logic       sw;
      logic [2:0] st;
      logic       gsr;
      logic       gts;
      logic [2:0] dom;
      logic       rdy;
      logic [7:0] rc;
   } vec_t;
   vec_t tbl[$];

   red_pitaya_rst_seq u_dut (
      .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .sw_rst_i(sw),
      .gsr_o(gsr), .prld_o(prld), .gts_o(gts), .dom_rstn_o(dom),
      .ready_o(rdy), .state_o(st), .restart_cnt_o(rc)
   );

   red_pitaya_rst_seq #(.TOC_CYCLES(0)) u_toc0 (
      .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .sw_rst_i(sw),
      .gsr_o(z_gsr), .prld_o(z_prld), .gts_o(z_gts), .dom_rstn_o(z_dom),
      .ready_o(z_rdy), .state_o(z_st), .restart_cnt_o(z_rc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int n, input logic p, input logic s, input logic [2:0] est,
                      input logic eg, input logic et, input logic [2:0] ed, input logic er,
                      input logic [7:0] erc);
      vec_t v;
      v = '{n, p, s, est, eg, et, ed, er, erc};
      tbl.push_back(v);
   endtask

   task automatic chk_all(input string tag, input logic [2:0] est, input logic eg, input logic et,
                          input logic [2:0] ed, input logic er, input logic [7:0] erc);
      chk({tag, "_state"}, 32'(st), 32'(est));
      chk({tag, "_gsr"}, 32'(gsr), 32'(eg));
      chk({tag, "_prld"}, 32'(prld), 32'(eg));
      chk({tag, "_gts"}, 32'(gts), 32'(et));
      chk({tag, "_dom"}, 32'(dom), 32'(ed));
      chk({tag, "_ready"}, 32'(rdy), 32'(er));
      chk({tag, "_rcnt"}, 32'(rc), 32'(erc));
   endtask

   task automatic wait_state(input logic [2:0] t, input int budget);
      for (int k = 0; k < budget && st != t; k++) tick();
      chk("wait_state", 32'(st), 32'(t));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sw  = 1'b0;
      pll = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int k;
      // full sequence, lock loss, re-lock, software reset during RELEASE
      add(1,  1, 0, 3'd1, 1, 1, 3'b000, 0, 8'd0);
      add(9,  1, 0, 3'd1, 1, 1, 3'b000, 0, 8'd0);
      add(1,  1, 0, 3'd2, 1, 1, 3'b000, 0, 8'd0);
      add(15, 1, 0, 3'd2, 1, 1, 3'b000, 0, 8'd0);
      add(1,  1, 0, 3'd3, 0, 1, 3'b000, 0, 8'd0);
      add(3,  1, 0, 3'd3, 0, 1, 3'b000, 0, 8'd0);
      add(1,  1, 0, 3'd4, 0, 0, 3'b001, 0, 8'd0);
      add(1,  1, 0, 3'd4, 0, 0, 3'b001, 0, 8'd0);
      add(1,  1, 0, 3'd4, 0, 0, 3'b011, 0, 8'd0);
      add(2,  1, 0, 3'd4, 0, 0, 3'b111, 0, 8'd0);
      add(1,  1, 0, 3'd5, 0, 0, 3'b111, 1, 8'd0);
      add(10, 1, 0, 3'd5, 0, 0, 3'b111, 1, 8'd0);
      add(2,  0, 0, 3'd5, 0, 0, 3'b111, 1, 8'd0);
      add(1,  0, 0, 3'd1, 1, 1, 3'b000, 0, 8'd1);
      add(5,  0, 0, 3'd1, 1, 1, 3'b000, 0, 8'd1);
      add(10, 1, 0, 3'd1, 1, 1, 3'b000, 0, 8'd1);
      add(1,  1, 0, 3'd2, 1, 1, 3'b000, 0, 8'd1);
      add(20, 1, 0, 3'd4, 0, 0, 3'b001, 0, 8'd1);
      add(2,  1, 0, 3'd4, 0, 0, 3'b011, 0, 8'd1);
      add(1,  1, 1, 3'd1, 1, 1, 3'b000, 0, 8'd2);
      add(8,  1, 0, 3'd1, 1, 1, 3'b000, 0, 8'd2);
      add(1,  1, 0, 3'd2, 1, 1, 3'b000, 0, 8'd2);

      tick();
      tick();
      chk_all("reset", 3'd0, 1, 1, 3'b000, 0, 8'd0);
      rst = 1'b0;
      foreach (tbl[i]) begin
         pll = tbl[i].pll;
         for (int j = 0; j < tbl[i].n; j++) begin
            sw = (j == 0) ? tbl[i].sw : 1'b0;
            tick();
         end
         sw = 1'b0;
         chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].gsr, tbl[i].gts, tbl[i].dom, tbl[i].rdy, tbl[i].rc);
      end

      // one-cycle lock glitch after five filter counts delays HOLD_GSR entry from tick 11 to 18
      do_reset();
      k = 0;
      for (int t = 1; t <= 100 && k == 0; t++) begin
         pll = (t == 7) ? 1'b0 : 1'b1;
         tick();
         if (st == 3'd2) k = t;
      end
      pll = 1'b1;
      chk("glitch_entry", 32'(k), 32'd18);
      chk("glitch_rcnt", 32'(rc), 32'd0);
      chk("toc0_entry", 32'(z_st), 32'd2);
      // zero TOC: GSR and GTS drop together and RELEASE follows directly
      repeat (15) tick();
      chk("toc0_hold_gsr", 32'(z_gsr), 32'd1);
      chk("toc0_hold_gts", 32'(z_gts), 32'd1);
      tick();
      chk("toc0_rel_state", 32'(z_st), 32'd4);
      chk("toc0_rel_gsr", 32'(z_gsr), 32'd0);
      chk("toc0_rel_prld", 32'(z_prld), 32'd0);
      chk("toc0_rel_gts", 32'(z_gts), 32'd0);
      chk("toc0_rel_dom", 32'(z_dom), 32'd1);
      repeat (5) tick();
      chk("toc0_run_state", 32'(z_st), 32'd5);
      chk("toc0_run_ready", 32'(z_rdy), 32'd1);
      chk("toc0_run_dom", 32'(z_dom), 32'd7);

      // restart counter saturation, then reset in the middle of HOLD_GTS
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         wait_state(3'd2, 50);
         sw = 1'b1;
         tick();
         sw = 1'b0;
         if (i == 254) chk("rcnt_254", 32'(rc), 32'd254);
         if (i == 255) chk("rcnt_255", 32'(rc), 32'd255);
      end
      chk("rcnt_sat", 32'(rc), 32'd255);
      wait_state(3'd3, 100);
      tick();
      rst = 1'b1;
      tick();
      chk_all("rst_mid_gts", 3'd0, 1, 1, 3'b000, 0, 8'd0);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
